sqrt_issue_queue: RTL and testbench
===================================

Name: sqrt_issue_queue

Overview:
Upstream feeder for the f32 square-root unit. It accepts IEEE-754 single-precision operands on a valid/ready stream and buffers them in a small FIFO. Each operand is presented to the square-root unit with its enable held until the unit signals ready, and the result is returned on an output valid/ready stream. This isolates producers from the sqrt unit's variable latency and its enable-driven internal reset.

Parameters:
WIDTH, 32, operand/result width (f32 bit pattern)
DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles waiting for sq_rdy (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand available
in_ready  out  1  FIFO can accept (not full)
in_data  in  WIDTH  operand bit pattern
sq_en  out  1  enable to sqrt unit
sq_a  out  WIDTH  operand to sqrt unit
sq_rdy  in  1  sqrt unit result valid
sq_result  in  WIDTH  sqrt unit result
out_valid  out  1  result held
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  result bit pattern
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0, async) clears all state. Outputs: in_ready=1, sq_en=0, sq_a=0, out_valid=0, out_data=0, fifo_count=0, busy=0. FSM goes to IDLE. Reset mid-operation abandons the operand in flight; its result is never emitted.
- FIFO:
  - Push on in_valid&&in_ready; pop when the FSM leaves IDLE/GAP for ISSUE.
  - Push and pop in the same cycle leave the count unchanged, and are legal even when full; in_ready stays low when full.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: sq_en=0. Moves to ISSUE when the FIFO is non-empty and the output slot is free (out_valid=0, or out_valid&&out_ready this cycle).
  - ISSUE: sq_en=1; sq_a holds the popped operand, stable for the whole state. When sq_rdy=1, capture sq_result into out_data, set out_valid, and go to GAP.
  - GAP: sq_en=0 for exactly one cycle so the sqrt unit re-initialises. Next state is ISSUE if the IDLE entry condition holds, else IDLE.
- Latency: an operand entering an empty, idle queue reaches sq_a with sq_en=1 two cycles after the push cycle (one cycle for the FIFO write, one for the pop/ISSUE entry). A result appears on out_data the cycle after sq_rdy.
- Output register: out_valid stays high and out_data stable until out_ready. A new capture never overwrites an unaccepted result; the entry condition into ISSUE guarantees this.
- sq_rdy is ignored outside ISSUE.
- Operand bits pass through unmodified. The block performs no floating-point interpretation.
- busy = (state!=IDLE) || (fifo_count!=0).

Optional Feature:
Macro SQRT_ISSUE_TIMEOUT_EN.
- With the macro: a counter runs while in ISSUE. If it reaches TIMEOUT without sq_rdy, the FSM aborts to GAP and emits out_data=32'h7FC00000 (quiet NaN) with out_valid=1. It also pulses the extra output port timeout_err (1 bit, reset 0) high for one cycle. The counter clears on ISSUE entry.
- Without the macro: the port, counter and abort path are absent, and ISSUE waits indefinitely.

Decomposition:
- Shared package sqrt_issue_pkg holds:
  - the state enum (IDLE, ISSUE, GAP);
  - the localparam QNAN_F32=32'h7FC00000;
  - a count-width function/constant derived from DEPTH.
- One sub-module, sqrt_issue_fifo: synchronous-write FIFO with count, full/empty, async active-low reset, parameterised WIDTH/DEPTH. FSM and output register stay in the top.

Test Plan:
- Single op: bench sqrt model with latency 5. Push 32'h41800000 (16.0). Expect sq_en high for 5 cycles with sq_a=32'h41800000, then out_valid=1, out_data=32'h40800000. Next cycle sq_en=0.
- Back-to-back: push 16.0, 9.0 (32'h41100000), 4.0 in consecutive cycles, out_ready=1. Expect results 4.0, 3.0 (32'h40400000), 2.0 (32'h40000000) in order. Exactly one sq_en=0 cycle separates each issue.
- Backpressure/full: out_ready=0, push DEPTH+2 operands. Expect in_ready=0 once fifo_count=DEPTH, first result held stable, and no second issue. Raising out_ready drains everything in order with no loss.
- Simultaneous push/pop at full: when the FSM pops, push in the same cycle. Expect fifo_count to stay DEPTH and the new operand to be delivered last.
- Reset mid-ISSUE: drop rst during ISSUE with 2 entries queued. Expect immediate sq_en=0, out_valid=0, fifo_count=0. After release, no stale result appears.
- Timeout (SQRT_ISSUE_TIMEOUT_EN, TIMEOUT=8): model never asserts sq_rdy. After 8 ISSUE cycles expect out_data=32'h7FC00000, out_valid=1, and a one-cycle timeout_err pulse; the next queued operand then issues normally.

Source files
------------

// File: rtl/sqrt_issue_pkg.sv
// sqrt_issue_pkg: shared state encoding, quiet-NaN constant and FIFO count width helper
package sqrt_issue_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
  localparam logic [31:0] QNAN_F32 = 32'h7FC00000;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sqrt_issue_queue_if.sv
// sqrt_issue_queue_if: operand/result streams and sqrt-unit handshake; SQRT_ISSUE_TIMEOUT_EN adds timeout_err
interface sqrt_issue_queue_if
  import sqrt_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      sq_en;
  logic [WIDTH-1:0]          sq_a;
  logic                      sq_rdy;
  logic [WIDTH-1:0]          sq_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [cnt_w(DEPTH)-1:0]   fifo_count;
  logic                      busy;
`ifdef SQRT_ISSUE_TIMEOUT_EN
  logic                      timeout_err;
  modport slave (
    input  in_valid, in_data, sq_rdy, sq_result, out_ready,
    output in_ready, sq_en, sq_a, out_valid, out_data, fifo_count, busy, timeout_err
  );
  modport master (
    output in_valid, in_data, sq_rdy, sq_result, out_ready,
    input  in_ready, sq_en, sq_a, out_valid, out_data, fifo_count, busy, timeout_err
  );
`else
  modport slave (
    input  in_valid, in_data, sq_rdy, sq_result, out_ready,
    output in_ready, sq_en, sq_a, out_valid, out_data, fifo_count, busy
  );
  modport master (
    output in_valid, in_data, sq_rdy, sq_result, out_ready,
    input  in_ready, sq_en, sq_a, out_valid, out_data, fifo_count, busy
  );
`endif
endinterface

// File: rtl/sqrt_issue_fifo.sv
// sqrt_issue_fifo: register-based operand FIFO with occupancy count, async active-low reset
module sqrt_issue_fifo
  import sqrt_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sqrt_issue_queue.sv
// sqrt_issue_queue: buffers f32 operands and issues them one at a time to the sqrt unit; SQRT_ISSUE_TIMEOUT_EN adds an ISSUE watchdog
module sqrt_issue_queue
  import sqrt_issue_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  sqrt_issue_queue_if.slave  bus
);
  localparam int CW = cnt_w(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sqrt_issue_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sq_a_q, sq_a_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full, fifo_empty, entry, pop;
  sqrt_issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid && bus.in_ready),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // Only issue when the result slot is free or being drained, so a capture never overwrites
  assign entry = !fifo_empty && (!out_valid_q || bus.out_ready);
  assign pop   = entry && state_q != ISSUE;
`ifdef SQRT_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          terr_q, terr_d;
`endif
  always_comb begin
    state_d     = state_q;
    sq_a_d      = sq_a_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
`ifdef SQRT_ISSUE_TIMEOUT_EN
    tmo_d       = '0;
    terr_d      = 1'b0;
`endif
    case (state_q)
      IDLE, GAP: begin
        state_d = entry ? ISSUE : IDLE;
        sq_a_d  = entry ? fifo_rdata : sq_a_q;
      end
      ISSUE: begin
        if (bus.sq_rdy) begin
          out_data_d  = bus.sq_result;
          out_valid_d = 1'b1;
          state_d     = GAP;
        end
`ifdef SQRT_ISSUE_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          out_data_d  = WIDTH'(QNAN_F32);
          out_valid_d = 1'b1;
          terr_d      = 1'b1;
          state_d     = GAP;
        end else tmo_d = tmo_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sq_a_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SQRT_ISSUE_TIMEOUT_EN
      tmo_q       <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sq_a_q      <= sq_a_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SQRT_ISSUE_TIMEOUT_EN
      tmo_q       <= tmo_d;
      terr_q      <= terr_d;
`endif
    end
  end
  assign bus.in_ready   = !fifo_full;
  assign bus.sq_en      = state_q == ISSUE;
  assign bus.sq_a       = sq_a_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.fifo_count = fifo_cnt;
  assign bus.busy       = state_q != IDLE || fifo_cnt != '0;
`ifdef SQRT_ISSUE_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
`endif
endmodule

// File: tb/tb_sqrt_issue_queue.sv
// tb_sqrt_issue_queue: directed bench with a fixed-latency sqrt model; covers SQRT_ISSUE_TIMEOUT_EN when defined
module tb_sqrt_issue_queue;
  localparam int W = 32, D = 4, LAT = 5;
  logic clk = 1'b0, rst = 1'b1, hang = 1'b0;
  int n_checks = 0, n_fails = 0, lat_cnt, low_run = 0;
  logic prev_en = 1'b0, seen = 1'b0;
  logic [31:0] got [$];
  int gaps [$];
  always #5 clk = ~clk;
  sqrt_issue_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();
  sqrt_issue_queue #(.WIDTH(W), .DEPTH(D), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] f_sqrt(input logic [31:0] a);
    case (a)
      32'h41800000: return 32'h40800000;
      32'h41100000: return 32'h40400000;
      32'h40800000: return 32'h40000000;
      32'h3F800000: return 32'h3F800000;
      32'h41C80000: return 32'h40A00000;
      32'h42100000: return 32'h40C00000;
      32'h00000000: return 32'h00000000;
      default:      return ~a;
    endcase
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lat_cnt <= 0;
    else lat_cnt <= bus.sq_en ? lat_cnt + 1 : 0;
  end
  assign bus.sq_rdy    = bus.sq_en && !hang && lat_cnt == LAT - 1;
  assign bus.sq_result = f_sqrt(bus.sq_a);
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.sq_en && !prev_en && seen) gaps.push_back(low_run);
    low_run <= bus.sq_en ? 0 : low_run + 1;
    prev_en <= bus.sq_en;
    seen    <= seen || bus.sq_en;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    logic acc;
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (acc) bus.in_valid = 1'b0;
  endtask
  task automatic push(input logic [31:0] d);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_valid && k < 50) begin
      tick();
      k++;
    end
    check("push_accept", {31'b0, bus.in_valid}, 32'd0);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("result_count", 32'(got.size()), 32'(n));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int base, gb;
    logic [31:0] ops [6];
    logic [31:0] res [6];
    ops = '{32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000, 32'h41C80000, 32'h42100000};
    res = '{32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000, 32'h40A00000, 32'h40C00000};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_sq_en", {31'b0, bus.sq_en}, 32'd0);
    check("rst_sq_a", bus.sq_a, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    rst = 1'b1;
    tick();
    // single operand, model latency 5
    push(ops[0]);
    check("single_cnt", 32'(bus.fifo_count), 32'd1);
    check("single_busy", {31'b0, bus.busy}, 32'd1);
    check("single_en0", {31'b0, bus.sq_en}, 32'd0);
    tick();
    check("single_sq_a", bus.sq_a, ops[0]);
    for (int i = 0; i < LAT; i++) begin
      check("single_en", {31'b0, bus.sq_en}, 32'd1);
      check("single_noval", {31'b0, bus.out_valid}, 32'd0);
      if (i < LAT - 1) tick();
    end
    tick();
    check("single_valid", {31'b0, bus.out_valid}, 32'd1);
    check("single_data", bus.out_data, res[0]);
    check("single_gap_en", {31'b0, bus.sq_en}, 32'd0);
    tick();
    check("single_hold", bus.out_data, res[0]);
    bus.out_ready = 1'b1;
    tick();
    check("single_drained", {31'b0, bus.out_valid}, 32'd0);
    check("single_idle", {31'b0, bus.busy}, 32'd0);
    // back-to-back
    base = got.size(); gb = gaps.size();
    push(ops[0]);
    push(ops[1]);
    check("b2b_pushpop_cnt", 32'(bus.fifo_count), 32'd1);
    push(ops[2]);
    check("b2b_cnt", 32'(bus.fifo_count), 32'd2);
    wait_got(base + 3, 100);
    for (int i = 0; i < 3; i++) check($sformatf("b2b_res%0d", i), got[base + i], res[i]);
    check("b2b_gap1", 32'(gaps[gb + 1]), 32'd1);
    check("b2b_gap2", 32'(gaps[gb + 2]), 32'd1);
    // backpressure and full
    repeat (3) tick();
    bus.out_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) push(ops[i]);
    check("full_cnt", 32'(bus.fifo_count), 32'd4);
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1; bus.in_data = ops[5];
    repeat (8) tick();
    check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp_data", bus.out_data, res[0]);
    check("bp_no_issue", {31'b0, bus.sq_en}, 32'd0);
    check("bp_cnt", 32'(bus.fifo_count), 32'd4);
    check("bp_none_taken", 32'(got.size()), 32'(base));
    repeat (3) tick();
    check("bp_stable", bus.out_data, res[0]);
    check("bp_still_idle", {31'b0, bus.sq_en}, 32'd0);
    bus.out_ready = 1'b1;
    wait_got(base + 6, 200);
    for (int i = 0; i < 6; i++) check($sformatf("drain_res%0d", i), got[base + i], res[i]);
    check("drain_cnt", 32'(bus.fifo_count), 32'd0);
    check("drain_busy", {31'b0, bus.busy}, 32'd0);
    // reset mid-ISSUE with two entries queued
    push(ops[0]); push(ops[1]); push(ops[2]);
    check("pre_rst_cnt", 32'(bus.fifo_count), 32'd2);
    check("pre_rst_en", {31'b0, bus.sq_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_en", {31'b0, bus.sq_en}, 32'd0);
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_cnt", 32'(bus.fifo_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    base = got.size();
    repeat (15) tick();
    check("post_rst_nores", 32'(got.size()), 32'(base));
    check("post_rst_en", {31'b0, bus.sq_en}, 32'd0);
    check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
`ifdef SQRT_ISSUE_TIMEOUT_EN
    hang = 1'b1;
    base = got.size();
    push(ops[0]);
    push(ops[1]);
    for (int i = 0; i < 7; i++) begin
      check("tmo_en", {31'b0, bus.sq_en}, 32'd1);
      check("tmo_err_low", {31'b0, bus.timeout_err}, 32'd0);
      tick();
    end
    check("tmo_last_en", {31'b0, bus.sq_en}, 32'd1);
    tick();
    hang = 1'b0;
    check("tmo_valid", {31'b0, bus.out_valid}, 32'd1);
    check("tmo_data", bus.out_data, 32'h7FC00000);
    check("tmo_err", {31'b0, bus.timeout_err}, 32'd1);
    check("tmo_gap_en", {31'b0, bus.sq_en}, 32'd0);
    tick();
    check("tmo_err_pulse", {31'b0, bus.timeout_err}, 32'd0);
    check("tmo_next_issue", {31'b0, bus.sq_en}, 32'd1);
    wait_got(base + 2, 100);
    check("tmo_res0", got[base], 32'h7FC00000);
    check("tmo_res1", got[base + 1], res[1]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
